// File: rtl/hilo_muldiv_if.sv
// Operand/result bus between the EX stage and the HI/LO multiply/divide engine.
interface hilo_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Start;
   logic [2:0]       Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic             Flush;
   logic             Busy;
   logic [WIDTH-1:0] WriteHiData;
   logic [WIDTH-1:0] WriteLoData;
   logic             WriteEn;
   logic             Madd;
   logic             Msub;

   modport master (
      output Start, Op, OperandA, OperandB, Flush,
      input  Busy, WriteHiData, WriteLoData, WriteEn, Madd, Msub
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, Flush,
      output Busy, WriteHiData, WriteLoData, WriteEn, Madd, Msub
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine producing HI/LO register-file writes.
// One shift-add or restoring-divide step per cycle over WIDTH cycles, then a
// sign-fix cycle, then a one-cycle DONE where exactly one strobe fires.
module hilo_muldiv_unit #(
   parameter int unsigned      WIDTH   = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
   input logic          Clk,
   input logic          Rst_n,
   hilo_muldiv_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;      // working accumulator / remainder:quotient
   logic [WIDTH-1:0] b_q;             // multiplicand or divisor magnitude
   logic [WIDTH-1:0] a_q;             // raw A, needed for the divide-by-zero HI
   logic             sa_q, sb_q;      // operand signs (0 for unsigned ops)
   logic [WIDTH-1:0] whi_q, wlo_q;
   logic [2:0]       strb_q;          // {msub, madd, wen}

   logic             is_div, is_sgn, in_sgn;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] hi_d, lo_d, fhi_d, flo_d;
   logic [WIDTH:0]   add_w, shl_w, sub_w;
   logic [2*WIDTH-1:0] prod_w;
   logic [2:0]       strb_d;

   assign is_div = (op_q[2:1] == 2'b01);
   assign is_sgn = ~op_q[0];
   assign in_sgn = ~bus.Op[0];
   assign a_mag  = (in_sgn && bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
   assign b_mag  = (in_sgn && bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;

   // One iteration: shift-add for multiply, restoring subtract for divide.
   // A remainder below the divisor doubled stays under 2*b, so a clear top
   // bit of the trial difference means the subtraction did not underflow.
   always_comb begin
      add_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shl_w = {hi_q, lo_q[WIDTH-1]};
      sub_w = shl_w - {1'b0, b_q};
      if (is_div) begin
         if (!sub_w[WIDTH]) begin
            hi_d = sub_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = shl_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_d = add_w[WIDTH:1];
         lo_d = {add_w[0], lo_q[WIDTH-1:1]};
      end
   end

   // Sign correction and divide-by-zero override applied in FIX.
   always_comb begin
      prod_w = {hi_q, lo_q};
      if (is_sgn && (sa_q ^ sb_q)) prod_w = -prod_w;
      fhi_d = prod_w[2*WIDTH-1:WIDTH];
      flo_d = prod_w[WIDTH-1:0];
      if (is_div) begin
         if (b_q == '0) begin
            fhi_d = a_q;
            flo_d = DIV0_LO;
         end else begin
            flo_d = (is_sgn && (sa_q ^ sb_q)) ? -lo_q : lo_q;
            fhi_d = (is_sgn && sa_q) ? -hi_q : hi_q;
         end
      end
      case (op_q[2:1])
         2'b10:   strb_d = 3'b010;
         2'b11:   strb_d = 3'b100;
         default: strb_d = 3'b001;
      endcase
   end

   // Control FSM and datapath registers; Flush overrides every transition.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         a_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         whi_q   <= '0;
         wlo_q   <= '0;
         strb_q  <= '0;
      end else if (bus.Flush) begin
         state_q <= IDLE;
         strb_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.Start) begin
               op_q    <= bus.Op;
               a_q     <= bus.OperandA;
               b_q     <= b_mag;
               hi_q    <= '0;
               lo_q    <= a_mag;
               sa_q    <= in_sgn & bus.OperandA[WIDTH-1];
               sb_q    <= in_sgn & bus.OperandB[WIDTH-1];
               cnt_q   <= '0;
               state_q <= CALC;
            end
            CALC: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
            end
            FIX: begin
               whi_q   <= fhi_d;
               wlo_q   <= flo_d;
               strb_q  <= strb_d;
               state_q <= DONE;
            end
            default: begin
               strb_q  <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.Busy        = (state_q != IDLE);
   assign bus.WriteHiData = whi_q;
   assign bus.WriteLoData = wlo_q;
   assign bus.WriteEn     = strb_q[0] & ~bus.Flush;
   assign bus.Madd        = strb_q[1] & ~bus.Flush;
   assign bus.Msub        = strb_q[2] & ~bus.Flush;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: vector table + random ops through
// a scoreboard, plus hand sequences for timing, Start-while-busy, Flush, reset.
module tb_hilo_muldiv_unit;
   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [2:0]  stb;   // {msub, madd, wen}
   } exp_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   int   ncmp = 0;
   int   nerr = 0;
   int   nstb = 0;
   exp_t sb[$];
   vec_t tbl[14];

   hilo_muldiv_if #(.WIDTH(32)) bus();

   hilo_muldiv_unit #(.WIDTH(32)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hi, input logic [31:0] lo, input logic [2:0] stb);
      vec_t v;
      v.op = op; v.a = a; v.b = b;
      v.e.hi = hi; v.e.lo = lo; v.e.stb = stb;
      return v;
   endfunction

   // Behavioural reference using native 64-bit arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [63:0] sa, sbv, q, r;
      logic [63:0] p;
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      if (op[2:1] == 2'b01) begin
         if (b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFFFFFF;
         end else if (!op[0]) begin
            q = sa / sbv; r = sa % sbv;
            e.lo = q[31:0]; e.hi = r[31:0];
         end else begin
            e.lo = a / b; e.hi = a % b;
         end
      end else begin
         if (op[0]) p = {32'd0, a} * {32'd0, b};
         else       p = sa * sbv;
         e.hi = p[63:32]; e.lo = p[31:0];
      end
      case (op[2:1])
         2'b10:   e.stb = 3'b010;
         2'b11:   e.stb = 3'b100;
         default: e.stb = 3'b001;
      endcase
      return e;
   endfunction

   // Scoreboard: every strobe must match the oldest expected result.
   always @(negedge Clk) begin
      if (Rst_n && (bus.WriteEn || bus.Madd || bus.Msub)) begin
         exp_t e;
         nstb++;
         if (sb.size() == 0) begin
            chk("unexpected strobe", {61'd0, bus.Msub, bus.Madd, bus.WriteEn}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("hi",     {32'd0, bus.WriteHiData}, {32'd0, e.hi});
            chk("lo",     {32'd0, bus.WriteLoData}, {32'd0, e.lo});
            chk("strobe", {61'd0, bus.Msub, bus.Madd, bus.WriteEn}, {61'd0, e.stb});
         end
      end
   end

   // Called at #1 after a rising edge; returns the same way once idle again.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      for (int i = 0; i < 100 && bus.Busy; i++) begin
         @(posedge Clk); #1;
      end
      chk("op completes", {63'd0, bus.Busy}, 64'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n0;
      logic [2:0] rop;
      logic [31:0] ra, rb;

      tbl[0]  = mk(3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 3'b001);
      tbl[1]  = mk(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3'b001);
      tbl[2]  = mk(3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       3'b001);
      tbl[3]  = mk(3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 3'b001);
      tbl[4]  = mk(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 3'b001);
      tbl[5]  = mk(3'b010, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 3'b001);
      tbl[6]  = mk(3'b100, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFA, 3'b010);
      tbl[7]  = mk(3'b111, 32'd4,        32'd5,        32'd0,        32'd20,       3'b100);
      tbl[8]  = mk(3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 3'b001);
      tbl[9]  = mk(3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 3'b001);
      tbl[10] = mk(3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        3'b001);
      tbl[11] = mk(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        3'b100);
      tbl[12] = mk(3'b101, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 3'b010);
      tbl[13] = mk(3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        3'b001);

      bus.Start = 1'b0; bus.Op = 3'b000; bus.OperandA = '0; bus.OperandB = '0; bus.Flush = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("reset busy", {63'd0, bus.Busy}, 64'd0);
      chk("reset hi",   {32'd0, bus.WriteHiData}, 64'd0);
      chk("reset lo",   {32'd0, bus.WriteLoData}, 64'd0);
      chk("reset strobes", {61'd0, bus.Msub, bus.Madd, bus.WriteEn}, 64'd0);
      Rst_n = 1'b1;
      @(posedge Clk); #1;

      // Cycle-exact timing; Start at N+10 and in DONE (N+34) must be ignored.
      sb.push_back(tbl[0].e);
      n0 = nstb;
      bus.Start = 1'b1; bus.Op = tbl[0].op; bus.OperandA = tbl[0].a; bus.OperandB = tbl[0].b;
      for (int k = 1; k <= 36; k++) begin
         @(posedge Clk); #1;
         bus.Start = (k == 10) || (k == 34);
         if (k == 10 || k == 34) begin
            bus.Op = 3'b011; bus.OperandA = 32'd9; bus.OperandB = 32'd3;
         end
         chk($sformatf("busy N+%0d", k), {63'd0, bus.Busy}, {63'd0, (k <= 34)});
         chk($sformatf("strobes N+%0d", k), {61'd0, bus.Msub, bus.Madd, bus.WriteEn},
             (k == 34) ? 64'd1 : 64'd0);
      end
      bus.Start = 1'b0;
      repeat (40) @(posedge Clk);
      #1;
      chk("single strobe", 64'(nstb - n0), 64'd1);

      // Table vectors through the scoreboard.
      for (int i = 0; i < 14; i++) begin
         sb.push_back(tbl[i].e);
         run_op(tbl[i].op, tbl[i].a, tbl[i].b);
      end

      // Random operations checked against the reference model.
      for (int i = 0; i < 12; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 20)) : $urandom);
         sb.push_back(model(rop, ra, rb));
         run_op(rop, ra, rb);
      end

      // Flush at N+20: no strobe, idle at N+21.
      n0 = nstb;
      bus.Start = 1'b1; bus.Op = 3'b001; bus.OperandA = 32'd6; bus.OperandB = 32'd7;
      for (int k = 1; k <= 21; k++) begin
         @(posedge Clk); #1;
         bus.Start = 1'b0;
         bus.Flush = (k == 20);
      end
      chk("flush busy N+21", {63'd0, bus.Busy}, 64'd0);

      // Start and Flush together in IDLE: Flush wins.
      bus.Start = 1'b1; bus.Flush = 1'b1;
      @(posedge Clk); #1;
      bus.Start = 1'b0; bus.Flush = 1'b0;
      chk("start+flush busy", {63'd0, bus.Busy}, 64'd0);

      // Flush in the DONE cycle gates the strobe combinationally.
      bus.Start = 1'b1; bus.Op = 3'b000; bus.OperandA = 32'd3; bus.OperandB = 32'd3;
      for (int k = 1; k <= 34; k++) begin
         @(posedge Clk); #1;
         bus.Start = 1'b0;
         bus.Flush = (k == 34);
      end
      #1;
      chk("flush in done strobes", {61'd0, bus.Msub, bus.Madd, bus.WriteEn}, 64'd0);
      @(posedge Clk); #1;
      bus.Flush = 1'b0;
      chk("flush in done busy", {63'd0, bus.Busy}, 64'd0);
      repeat (40) @(posedge Clk);
      #1;
      chk("no strobe after flushes", 64'(nstb - n0), 64'd0);

      // Reset at N+5 clears outputs immediately; no strobe afterwards.
      n0 = nstb;
      bus.Start = 1'b1; bus.Op = 3'b011; bus.OperandA = 32'd50; bus.OperandB = 32'd3;
      for (int k = 1; k <= 5; k++) begin
         @(posedge Clk); #1;
         bus.Start = 1'b0;
      end
      Rst_n = 1'b0;
      #1;
      chk("rst busy",   {63'd0, bus.Busy}, 64'd0);
      chk("rst hi",     {32'd0, bus.WriteHiData}, 64'd0);
      chk("rst lo",     {32'd0, bus.WriteLoData}, 64'd0);
      chk("rst strobes", {61'd0, bus.Msub, bus.Madd, bus.WriteEn}, 64'd0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      repeat (40) @(posedge Clk);
      #1;
      chk("no strobe after reset", 64'(nstb - n0), 64'd0);
      chk("scoreboard drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end
endmodule
